frac_mult_mac: RTL and testbench
================================

# frac_mult_mac

Parametrised, pipelined, fracturable multiplier-accumulator primitive for the multiplier logical tiles. It supports three modes, selected by configuration bits held in an internal scan-chain segment:

- one full DATA_W×DATA_W signed multiply,
- two independent half-width signed multiplies,
- a full-width multiply-accumulate.

Input and output register stages are optional and configurable. The block sits under the mult logical tile and joins the tile's ccff configuration chain through ccff_head/ccff_tail.

## Interface
Parameters:
- DATA_W, 18, operand width; must be even and ≥4; H = DATA_W/2.
- ACC_W, 48, accumulator/result width; must be ≥ 2*DATA_W.

Ports:
- clk  input  1  single clock for datapath and configuration chain.
- pResetn  input  1  asynchronous, active-low reset.
- config_enable  input  1  1 = shift configuration chain, datapath flushed.
- ccff_head  input  1  configuration chain serial in.
- ccff_tail  output  1  configuration chain serial out, equals cfg[3].
- en  input  1  datapath clock enable; 0 holds every datapath register.
- in_valid  input  1  operands valid this cycle.
- acc_clr  input  1  sampled with in_valid; restarts accumulation.
- a  input  DATA_W  operand A, two's complement.
- b  input  DATA_W  operand B, two's complement.
- out_valid  output  1  y holds a new result.
- y  output  ACC_W  result.
- ovf  output  1  sticky signed accumulator overflow.

## Operation
Configuration:
- cfg[3:0] is a shift register. When config_enable=1 it shifts every clk edge, regardless of en: cfg <= {cfg[2:0], ccff_head}.
- Bit meanings: cfg[0]=frac, cfg[1]=mac, cfg[2]=in_reg, cfg[3]=out_reg. The first bit shifted in lands in out_reg after four shifts.
- While config_enable=1, all valid bits, the accumulator and ovf are cleared, and out_valid=0.

Datapath stages:
- S0: optional input register for a, b, in_valid and acc_clr. Present when in_reg=1; otherwise it is a combinational bypass.
- S1: mandatory product/accumulator register.
- S2: optional output register for y, out_valid and ovf. Present when out_reg=1.

Arithmetic:
- frac=0, mac=0: P = sext(a)*sext(b), 2*DATA_W bits signed; y = P sign-extended to ACC_W.
- frac=1: mac is ignored.
  - Low half: a[H-1:0]*b[H-1:0] → signed 2H-bit result in y[2H-1:0].
  - High half: a[DATA_W-1:H]*b[DATA_W-1:H] → signed 2H-bit result in y[4H-1:2H].
  - y[ACC_W-1:4H] = 0.
- frac=0, mac=1, on each valid sample:
  - if acc_clr=1: acc <= sext(P), and ovf is cleared;
  - otherwise: acc <= acc + sext(P) modulo 2^ACC_W (wrap-around).
  - ovf is set when the signed addition overflows (both operand signs equal, sum sign differs) and stays set until the next acc_clr sample or reset.
  - y = acc.
- When in_valid=0, S1 holds acc and y, and out_valid drops to 0.
- acc_clr with in_valid=0 has no effect.
- In non-mac modes ovf=0.

## Timing
- Reset: cfg=0 (full multiply, no optional registers). y, acc, ovf, out_valid, ccff_tail and all valid bits are 0.
- Latency from in_valid to out_valid = 1 + in_reg + out_reg cycles (1 to 3). One result per cycle; there is no backpressure.
- en=0: every datapath register, including valid bits, holds its value. out_valid keeps its last value.
- config_enable=1 overrides en and flushes in-flight samples; they are lost.
- config_enable=1 and in_valid=1 in the same cycle: the sample is ignored.
- Reset asserted mid-operation: the block returns to its reset state immediately (asynchronous); configuration is lost.
- Mode changes take effect only through the chain. Results after a reconfiguration reflect the new cfg from the first valid sample.

## Test plan
- Reset, no configuration: a=18'h3FFFD (−3), b=5, in_valid=1 → one cycle later out_valid=1, y=48'hFFFF_FFFF_FFF1; ccff_tail=0.
- Shift 4'b0101 (sequence 0,1,0,1 = out_reg, in_reg, mac, frac), then a={9'd7,9'h003}, b={9'd2,9'h1FC} → out_valid 2 cycles later, y[17:0]=18'h3FFF4, y[35:18]=18'd14, y[47:36]=0.
- mac only, ACC_W=48: samples 1000×1000 with acc_clr=1, then three 1000×1000 without acc_clr → final y=4,000,000, ovf=0. A following sample with acc_clr=1 and 2×3 gives y=6.
- ACC_W=36, mac only: two samples of −131072×−131072 (first with acc_clr) → y=2^34, then y=−2^35 with ovf=1. A later acc_clr sample clears ovf.
- Chain passthrough: shift the 8-bit pattern 10110010 → ccff_tail replays the pattern delayed by 4 clk cycles.
- Stall/flush, in_reg=out_reg=1: en=0 for 3 cycles mid-stream → results delivered in order with no loss. Raising config_enable with 2 samples in flight → out_valid=0, and those samples never appear.

Source files
------------

// File: rtl/frac_mult_mac.sv
`default_nettype none
// ============================================================================
// frac_mult_mac : fracturable signed multiplier / accumulator, scan-configured
// Revision      : 1.0
// ============================================================================
module frac_mult_mac #(
  parameter int DATA_W = 18,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              pResetn,
  input  logic              config_enable,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic              en,
  input  logic              in_valid,
  input  logic              acc_clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  output logic [ACC_W-1:0]  y,
  output logic              ovf
);

  localparam int H  = DATA_W / 2;
  localparam int PW = 2 * DATA_W;

  logic [3:0] cfg;
  logic       frac_mode;
  logic       mac_mode;
  logic       in_reg;
  logic       out_reg;

  assign frac_mode = cfg[0];
  assign mac_mode  = cfg[1];
  assign in_reg    = cfg[2];
  assign out_reg   = cfg[3];
  assign ccff_tail = cfg[3];

  always_ff @(posedge clk or negedge pResetn) begin
    if (!pResetn) begin
      cfg <= '0;
    end else if (config_enable) begin
      cfg <= {cfg[2:0], ccff_head};
    end
  end

  // S0: optional input register, bypassed combinationally when in_reg=0
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              v_q;
  logic              clr_q;

  always_ff @(posedge clk or negedge pResetn) begin
    if (!pResetn) begin
      a_q   <= '0;
      b_q   <= '0;
      v_q   <= 1'b0;
      clr_q <= 1'b0;
    end else if (config_enable) begin
      v_q   <= 1'b0;
      clr_q <= 1'b0;
    end else if (en) begin
      a_q   <= a;
      b_q   <= b;
      v_q   <= in_valid;
      clr_q <= acc_clr;
    end
  end

  logic [DATA_W-1:0] a_s;
  logic [DATA_W-1:0] b_s;
  logic              v_s;
  logic              clr_s;

  assign a_s   = in_reg ? a_q   : a;
  assign b_s   = in_reg ? b_q   : b;
  assign v_s   = in_reg ? v_q   : in_valid;
  assign clr_s = in_reg ? clr_q : acc_clr;

  // Operands are sign-extended to the product width so the low bits of an
  // unsigned multiply give the exact signed product.
  logic [PW-1:0]  a_ext;
  logic [PW-1:0]  b_ext;
  logic [PW-1:0]  prod_full;
  logic [2*H-1:0] a_lo_ext;
  logic [2*H-1:0] b_lo_ext;
  logic [2*H-1:0] a_hi_ext;
  logic [2*H-1:0] b_hi_ext;
  logic [2*H-1:0] prod_lo;
  logic [2*H-1:0] prod_hi;

  assign a_ext     = {{DATA_W{a_s[DATA_W-1]}}, a_s};
  assign b_ext     = {{DATA_W{b_s[DATA_W-1]}}, b_s};
  assign prod_full = a_ext * b_ext;

  assign a_lo_ext  = {{H{a_s[H-1]}}, a_s[H-1:0]};
  assign b_lo_ext  = {{H{b_s[H-1]}}, b_s[H-1:0]};
  assign a_hi_ext  = {{H{a_s[DATA_W-1]}}, a_s[DATA_W-1:H]};
  assign b_hi_ext  = {{H{b_s[DATA_W-1]}}, b_s[DATA_W-1:H]};
  assign prod_lo   = a_lo_ext * b_lo_ext;
  assign prod_hi   = a_hi_ext * b_hi_ext;

  logic [ACC_W-1:0] p_ext;

  generate
    if (ACC_W > PW) begin : g_sext
      assign p_ext = {{(ACC_W-PW){prod_full[PW-1]}}, prod_full};
    end else begin : g_nosext
      assign p_ext = prod_full;
    end
  endgenerate

  logic [ACC_W-1:0] frac_y;

  always_comb begin
    frac_y                = '0;
    frac_y[2*H-1:0]       = prod_lo;
    frac_y[4*H-1:2*H]     = prod_hi;
  end

  // S1: product / accumulator stage
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             add_ovf;
  logic             ovf_acc;
  logic [ACC_W-1:0] y1;
  logic             v1;
  logic             ovf1;

  assign acc_sum = acc + p_ext;
  assign add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) &&
                   (acc_sum[ACC_W-1] != acc[ACC_W-1]);

  always_ff @(posedge clk or negedge pResetn) begin
    if (!pResetn) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
      y1      <= '0;
      v1      <= 1'b0;
    end else if (config_enable) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
      v1      <= 1'b0;
    end else if (en) begin
      v1 <= v_s;
      if (v_s) begin
        if (frac_mode) begin
          y1 <= frac_y;
        end else if (mac_mode) begin
          if (clr_s) begin
            acc     <= p_ext;
            ovf_acc <= 1'b0;
            y1      <= p_ext;
          end else begin
            acc     <= acc_sum;
            ovf_acc <= ovf_acc | add_ovf;
            y1      <= acc_sum;
          end
        end else begin
          y1 <= p_ext;
        end
      end
    end
  end

  assign ovf1 = ovf_acc & mac_mode & ~frac_mode;

  // S2: optional output register
  logic [ACC_W-1:0] y2;
  logic             v2;
  logic             ovf2;

  always_ff @(posedge clk or negedge pResetn) begin
    if (!pResetn) begin
      y2   <= '0;
      v2   <= 1'b0;
      ovf2 <= 1'b0;
    end else if (config_enable) begin
      v2   <= 1'b0;
      ovf2 <= 1'b0;
    end else if (en) begin
      y2   <= y1;
      v2   <= v1;
      ovf2 <= ovf1;
    end
  end

  assign y         = out_reg ? y2   : y1;
  assign ovf       = out_reg ? ovf2 : ovf1;
  assign out_valid = (out_reg ? v2 : v1) & ~config_enable;

endmodule
`default_nettype wire

// File: tb/tb_frac_mult_mac.sv
`default_nettype none
// ============================================================================
// tb_frac_mult_mac : directed self-checking bench, ACC_W=48 and ACC_W=36 copies
// Revision         : 1.0
// ============================================================================
module tb_frac_mult_mac;

  logic        clk = 1'b0;
  logic        pResetn;
  logic        config_enable;
  logic        ccff_head;
  logic        en;
  logic        in_valid;
  logic        acc_clr;
  logic [17:0] a;
  logic [17:0] b;

  logic        tail48, valid48, ovf48;
  logic [47:0] y48;
  logic        tail36, valid36, ovf36;
  logic [35:0] y36;

  int vectors    = 0;
  int miscompares = 0;

  logic [47:0] expq[$];
  int          delivered;
  logic [47:0] exp_head;

  always #5 clk = ~clk;

  frac_mult_mac #(.DATA_W(18), .ACC_W(48)) dut (
    .clk(clk), .pResetn(pResetn), .config_enable(config_enable),
    .ccff_head(ccff_head), .ccff_tail(tail48), .en(en),
    .in_valid(in_valid), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(valid48), .y(y48), .ovf(ovf48)
  );

  frac_mult_mac #(.DATA_W(18), .ACC_W(36)) dut36 (
    .clk(clk), .pResetn(pResetn), .config_enable(config_enable),
    .ccff_head(ccff_head), .ccff_tail(tail36), .en(en),
    .in_valid(in_valid), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(valid36), .y(y36), .ovf(ovf36)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_cfg(input logic [3:0] v);
    config_enable = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      ccff_head = v[i];
      tick();
    end
    config_enable = 1'b0;
    ccff_head     = 1'b0;
  endtask

  task automatic mac(input logic [17:0] aa, input logic [17:0] bb, input logic clr);
    a = aa; b = bb; acc_clr = clr; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; acc_clr = 1'b0;
  endtask

  function automatic logic [47:0] mul48(input logic [17:0] x, input logic [17:0] z);
    logic [47:0] xs;
    logic [47:0] zs;
    xs = {{30{x[17]}}, x};
    zs = {{30{z[17]}}, z};
    return xs * zs;
  endfunction

  // One pipelined cycle: outputs are only new when en was high at the edge.
  task automatic cyc(input logic e, input logic v, input logic [17:0] aa, input logic [17:0] bb);
    en = e; in_valid = v; a = aa; b = bb;
    if (e && v) expq.push_back(mul48(aa, bb));
    tick();
    if (e && valid48) begin
      delivered++;
      if (expq.size() == 0) begin
        check("stall_unexpected", 64'(valid48), 64'd0);
      end else begin
        exp_head = expq.pop_front();
        check("stall_result", 64'(y48), 64'(exp_head));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    pResetn = 1'b0; config_enable = 1'b0; ccff_head = 1'b0; en = 1'b1;
    in_valid = 1'b0; acc_clr = 1'b0; a = '0; b = '0; delivered = 0;
    #12;
    check("rst_y",     64'(y48),     64'd0);
    check("rst_valid", 64'(valid48), 64'd0);
    check("rst_ovf",   64'(ovf48),   64'd0);
    check("rst_tail",  64'(tail48),  64'd0);
    @(negedge clk);
    pResetn = 1'b1;
    tick();

    // Default full multiply, latency 1
    a = 18'h3FFFD; b = 18'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("full_valid", 64'(valid48), 64'd1);
    check("full_y48",   64'(y48),     64'h0000_FFFF_FFFF_FFF1);
    check("full_y36",   64'(y36),     64'h0000_000F_FFFF_FFF1);
    check("full_tail",  64'(tail48),  64'd0);
    tick();
    check("full_drop",  64'(valid48), 64'd0);

    // Fractured with input register, latency 2
    shift_cfg(4'b0101);
    a = {9'd7, 9'h003}; b = {9'd2, 9'h1FC}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("frac_lat1", 64'(valid48), 64'd0);
    tick();
    check("frac_valid", 64'(valid48), 64'd1);
    check("frac_y",     64'(y48),     64'({12'h000, 18'd14, 18'h3FFF4}));

    // MAC mode
    shift_cfg(4'b0010);
    mac(18'd1000, 18'd1000, 1'b1);
    check("mac_first", 64'(y48), 64'd1000000);
    mac(18'd1000, 18'd1000, 1'b0);
    check("mac_second", 64'(y48), 64'd2000000);
    mac(18'd1000, 18'd1000, 1'b0);
    mac(18'd1000, 18'd1000, 1'b0);
    check("mac_y48",   64'(y48),   64'd4000000);
    check("mac_ovf48", 64'(ovf48), 64'd0);
    check("mac_y36",   64'(y36),   64'd4000000);
    mac(18'd2, 18'd3, 1'b1);
    check("mac_clr_y", 64'(y48), 64'd6);

    mac(18'h20000, 18'h20000, 1'b1);
    check("big1_y48", 64'(y48), 64'h4_0000_0000);
    check("big1_y36", 64'(y36), 64'h4_0000_0000);
    mac(18'h20000, 18'h20000, 1'b0);
    check("big2_y48",   64'(y48),   64'h8_0000_0000);
    check("big2_ovf48", 64'(ovf48), 64'd0);
    check("big2_y36",   64'(y36),   64'h8_0000_0000);
    check("big2_ovf36", 64'(ovf36), 64'd1);
    acc_clr = 1'b1; in_valid = 1'b0;
    tick();
    acc_clr = 1'b0;
    check("idle_valid", 64'(valid36), 64'd0);
    check("idle_ovf",   64'(ovf36),   64'd1);
    check("idle_y",     64'(y36),     64'h8_0000_0000);
    mac(18'd2, 18'd3, 1'b1);
    check("clr_y36",   64'(y36),   64'd6);
    check("clr_ovf36", 64'(ovf36), 64'd0);

    // Chain passthrough of 10110010, tail delayed 4 shifts
    begin
      logic [7:0] pat;
      pat = 8'b1011_0010;
      config_enable = 1'b1;
      for (int k = 0; k < 8; k++) begin
        ccff_head = pat[7-k];
        tick();
        check("cfg_valid", 64'(valid48), 64'd0);
        if (k >= 3) check("chain_tail", 64'(tail48), 64'(pat[7-(k-3)]));
      end
      config_enable = 1'b0;
      ccff_head = 1'b0;
    end

    // Stall with in_reg=out_reg=1, latency 3
    shift_cfg(4'b1100);
    cyc(1'b1, 1'b1, 18'd3, 18'd4);
    cyc(1'b1, 1'b1, 18'h3FFF9, 18'd9);
    cyc(1'b1, 1'b1, 18'd100, 18'h3FF38);
    cyc(1'b1, 1'b1, 18'h1FFFF, 18'h1FFFF);
    cyc(1'b0, 1'b1, 18'd11, 18'd11);
    cyc(1'b0, 1'b1, 18'd11, 18'd11);
    cyc(1'b0, 1'b1, 18'd11, 18'd11);
    cyc(1'b1, 1'b1, 18'h20000, 18'd1);
    cyc(1'b1, 1'b1, 18'd5, 18'd5);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 18'd0, 18'd0);
    check("stall_delivered", 64'(delivered), 64'd6);
    check("stall_drained",   64'(expq.size()), 64'd0);

    // Flush two samples in flight by entering configuration
    cyc(1'b1, 1'b1, 18'd6, 18'd7);
    cyc(1'b1, 1'b1, 18'd8, 18'd9);
    expq.delete();
    config_enable = 1'b1; ccff_head = 1'b1; in_valid = 1'b1;
    #1;
    check("flush_now", 64'(valid48), 64'd0);
    for (int i = 3; i >= 0; i--) begin
      ccff_head = (i >= 2);
      tick();
      check("flush_cfg", 64'(valid48), 64'd0);
    end
    config_enable = 1'b0; ccff_head = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("flush_lost", 64'(valid48), 64'd0);
    end
    check("flush_tail", 64'(tail48), 64'd1);

    // Asynchronous reset mid-operation
    a = 18'd9; b = 18'd9; in_valid = 1'b1;
    tick();
    tick();
    pResetn = 1'b0;
    #1;
    check("arst_tail",  64'(tail48),  64'd0);
    check("arst_valid", 64'(valid48), 64'd0);
    check("arst_y",     64'(y48),     64'd0);
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
